// File: rtl/afifo_wptr_full_if.sv
// afifo_wptr_full_if
//   Bundles the write-side signals of the async FIFO write-pointer block.
//   master : the write-side user (drives wr_en_i and the synchronized read pointer)
//   slave  : the afifo_wptr_full block itself
//   Signals:
//     wr_en_i        write request for this cycle
//     rd_gray_sync_i read pointer in Gray code, already synchronized into clk
//     wr_addr_o      RAM write address
//     wr_gray_o      registered Gray write pointer for the read-domain synchronizer
//     wr_accept_o    RAM write strobe
//     full_o         FIFO full
//     almost_full_o  free slots at or below the threshold
//     overflow_o     sticky write-while-full error
interface afifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en_i;
  logic [ADDR_WIDTH:0]   rd_gray_sync_i;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [ADDR_WIDTH:0]   wr_gray_o;
  logic                  wr_accept_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic                  overflow_o;

  modport master (
    output wr_en_i,
    output rd_gray_sync_i,
    input  wr_addr_o,
    input  wr_gray_o,
    input  wr_accept_o,
    input  full_o,
    input  almost_full_o,
    input  overflow_o
  );

  modport slave (
    input  wr_en_i,
    input  rd_gray_sync_i,
    output wr_addr_o,
    output wr_gray_o,
    output wr_accept_o,
    output full_o,
    output almost_full_o,
    output overflow_o
  );
endinterface

// File: rtl/afifo_wptr_full.sv
// afifo_wptr_full
//   Write-domain pointer and status logic for an asynchronous FIFO.
//   Keeps the write pointer in binary and Gray form, drives the RAM write
//   address, publishes a flop-direct Gray pointer to the read domain and
//   derives full / almost-full / accept / sticky overflow from the read
//   pointer that has already been synchronized into this clock domain.
//   Ports:
//     clk   write-domain clock
//     reset asynchronous, active-low reset
//     bus   afifo_wptr_full_if.slave (see interface file for signal list)
//   Parameters:
//     ADDR_WIDTH          RAM address bits, depth = 2**ADDR_WIDTH (must be >= 2)
//     ALMOST_FULL_THRESH  almost-full when free slots <= this value
module afifo_wptr_full #(
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = 2
) (
  input logic              clk,
  input logic              reset,
  afifo_wptr_full_if.slave bus
);

  localparam int              A        = ADDR_WIDTH;
  localparam int              DEPTH    = 1 << A;
  localparam logic [A:0]      DEPTH_V  = DEPTH[A:0];
  localparam logic [A:0]      THRESH_V = ALMOST_FULL_THRESH[A:0];

  logic [A:0] wbin;
  logic [A:0] wgray;
  logic       full_q;
  logic       almost_q;
  logic       overflow_q;

  logic       accept;
  logic [A:0] wbin_next;
  logic [A:0] gray_next;
  logic [A:0] rbin;
  logic [A:0] full_cmp;
  logic [A:0] used_next;
  logic [A:0] free_next;
  logic       full_next;
  logic       almost_next;

  // Prefix XOR from the MSB turns a Gray code back into binary.
  function automatic logic [A:0] gray_to_bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A write is taken only when not full; gating with reset keeps the RAM
  // strobe quiet while the block is held in reset.
  always_comb begin
    accept = bus.wr_en_i && !full_q && reset;
  end

  // Next pointer in both encodings, plus the status it implies against the
  // synchronized read pointer. Status is computed from the next pointer so
  // full appears in the same cycle the pointer reaches depth.
  always_comb begin
    wbin_next   = wbin + {{A{1'b0}}, accept};
    gray_next   = wbin_next ^ (wbin_next >> 1);
    full_cmp    = {~bus.rd_gray_sync_i[A:A-1], bus.rd_gray_sync_i[A-2:0]};
    rbin        = gray_to_bin(bus.rd_gray_sync_i);
    used_next   = wbin_next - rbin;
    free_next   = DEPTH_V - used_next;
    full_next   = (gray_next == full_cmp);
    almost_next = (free_next <= THRESH_V);
  end

  // Pointer and status registers; overflow is sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbin       <= '0;
      wgray      <= '0;
      full_q     <= 1'b0;
      almost_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wgray    <= gray_next;
      full_q   <= full_next;
      almost_q <= almost_next;
      if (bus.wr_en_i && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // The Gray pointer leaves straight from its flop so the read-domain
  // synchronizer never sees combinational glitches.
  assign bus.wr_addr_o     = wbin[A-1:0];
  assign bus.wr_gray_o     = wgray;
  assign bus.wr_accept_o   = accept;
  assign bus.full_o        = full_q;
  assign bus.almost_full_o = almost_q;
  assign bus.overflow_o    = overflow_q;

endmodule

// File: tb/tb_afifo_wptr_full.sv
// tb_afifo_wptr_full
//   Scoreboard bench for afifo_wptr_full with ADDR_WIDTH=2 (depth 4) and
//   ALMOST_FULL_THRESH=1. Stimulus pushes the expected post-edge state into
//   a queue; a monitor process samples the DUT each cycle and pops/compares.
module tb_afifo_wptr_full;

  localparam int AW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    string      name;
    logic       acc;
    logic [2:0] gray;
    logic [1:0] addr;
    logic       full;
    logic       af;
    logic       ovf;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] prev_gray = '0;

  afifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

  afifo_wptr_full #(
    .ADDR_WIDTH        (AW),
    .ALMOST_FULL_THRESH(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 10-unit write clock
  always #5 clk = ~clk;

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] v;
    v = 3'(b % 8);
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks that every output is at its reset value right now.
  task automatic checkZeros(input string name);
    checkOutput({name, " accept"}, 8'(bus.wr_accept_o), 8'd0);
    checkOutput({name, " gray"}, 8'(bus.wr_gray_o), 8'd0);
    checkOutput({name, " addr"}, 8'(bus.wr_addr_o), 8'd0);
    checkOutput({name, " full"}, 8'(bus.full_o), 8'd0);
    checkOutput({name, " almost"}, 8'(bus.almost_full_o), 8'd0);
    checkOutput({name, " overflow"}, 8'(bus.overflow_o), 8'd0);
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the DUT
  // must show: accept before the rising edge, registered state after it.
  task automatic applyStimulus(input string name, input logic we, input int rdb,
                               input logic acc, input int ebin, input logic full,
                               input logic af, input logic ovf);
    exp_t e;
    @(negedge clk);
    bus.wr_en_i        = we;
    bus.rd_gray_sync_i = to_gray(rdb);
    e.name = name;
    e.acc  = acc;
    e.gray = to_gray(ebin);
    e.addr = 2'(ebin % 4);
    e.full = full;
    e.af   = af;
    e.ovf  = ovf;
    sb.push_back(e);
  endtask

  // Assert reset mid-cycle, check outputs clear before the next rising edge,
  // then release on a falling edge.
  task automatic doReset(input string name, input logic we);
    @(negedge clk);
    bus.wr_en_i = we;
    #3 reset = 1'b0;
    #1 checkZeros(name);
    @(negedge clk);
    bus.wr_en_i        = 1'b0;
    bus.rd_gray_sync_i = '0;
    reset              = 1'b1;
    prev_gray          = '0;
  endtask

  // Monitor: samples accept mid-cycle and the registers just after the edge.
  initial begin : monitor
    exp_t e;
    logic acc_s;
    forever begin
      @(negedge clk);
      #2 acc_s = bus.wr_accept_o;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({e.name, " accept"}, 8'(acc_s), 8'(e.acc));
        checkOutput({e.name, " gray"}, 8'(bus.wr_gray_o), 8'(e.gray));
        checkOutput({e.name, " addr"}, 8'(bus.wr_addr_o), 8'(e.addr));
        checkOutput({e.name, " full"}, 8'(bus.full_o), 8'(e.full));
        checkOutput({e.name, " almost"}, 8'(bus.almost_full_o), 8'(e.af));
        checkOutput({e.name, " overflow"}, 8'(bus.overflow_o), 8'(e.ovf));
        checkOutput({e.name, " gray step"},
                    8'($countones(prev_gray ^ bus.wr_gray_o) <= 1), 8'd1);
        prev_gray = bus.wr_gray_o;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #100000;
    n_errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : stimulus
    int   m_wp, m_rd, rd_d1, rd_d2, rs, nwp, used;
    logic we, acc, m_full, nfull, m_ovf, novf;

    bus.wr_en_i        = 1'b0;
    bus.rd_gray_sync_i = '0;
    #1 checkZeros("power-on reset");
    @(negedge clk);
    reset = 1'b1;

    // Reset: two writes, then a mid-cycle reset with a write in flight
    applyStimulus("t1 w1", 1, 0, 1, 1, 0, 0, 0);
    applyStimulus("t1 w2", 1, 0, 1, 2, 0, 0, 0);
    doReset("t1 midreset", 1'b1);

    // Fill against a stationary read pointer
    applyStimulus("t2 w1", 1, 0, 1, 1, 0, 0, 0);
    applyStimulus("t2 w2", 1, 0, 1, 2, 0, 0, 0);
    applyStimulus("t2 w3", 1, 0, 1, 3, 0, 1, 0);
    applyStimulus("t2 w4", 1, 0, 1, 4, 1, 1, 0);
    applyStimulus("t2 w5 refused", 1, 0, 0, 4, 1, 1, 1);
    applyStimulus("t2 idle", 0, 0, 0, 4, 1, 1, 1);

    // Drain one entry, then refill to full
    applyStimulus("t3 read", 0, 1, 0, 4, 0, 1, 1);
    applyStimulus("t3 refill", 1, 1, 1, 5, 1, 1, 1);

    // Wrap with the read pointer two writes behind
    doReset("t4 reset", 1'b0);
    for (int k = 0; k < 20; k++) begin
      int rdb;
      int u;
      rdb = (k >= 2) ? k - 2 : 0;
      u   = k + 1 - rdb;
      applyStimulus($sformatf("t4 k%0d", k), 1, rdb, 1, k + 1, 1'b0, (4 - u) <= 1, 0);
    end

    // Write and read-pointer advance together at used=3
    applyStimulus("t5 simul1", 1, 18, 1, 21, 0, 1, 0);
    applyStimulus("t5 simul2", 1, 19, 1, 22, 0, 1, 0);

    // Random writes against a slow reader seen two cycles late
    doReset("t6 reset", 1'b0);
    m_wp = 0; m_rd = 0; rd_d1 = 0; rd_d2 = 0;
    m_full = 1'b0; m_ovf = 1'b0;
    for (int c = 0; c < 40; c++) begin
      we    = ($urandom_range(0, 3) != 0);
      rs    = rd_d2;
      acc   = we && !m_full;
      nwp   = m_wp + int'(acc);
      used  = nwp - rs;
      nfull = (used == 4);
      novf  = m_ovf | (we && m_full);
      applyStimulus($sformatf("t6 c%0d", c), we, rs, acc, nwp, nfull, (4 - used) <= 1, novf);
      m_wp   = nwp;
      m_full = nfull;
      m_ovf  = novf;
      rd_d2  = rd_d1;
      rd_d1  = m_rd;
      if (m_rd < m_wp && $urandom_range(0, 2) == 0) m_rd++;
    end

    @(negedge clk);
    bus.wr_en_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 8'(sb.size() == 0), 8'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/afifo_wptr_full.md
Name: afifo_wptr_full

Overview:
- Write-domain pointer and status block for the async FIFO; one per write clock domain.
- Keeps the write pointer in binary and Gray form and drives the RAM write address.
- Publishes a flop-direct Gray pointer to the read domain, where a synchronizer captures it.
- Takes the read pointer, already synchronized into this domain, and derives full, almost-full, accept and a sticky overflow error.

Parameters:
- ADDR_WIDTH, 4: RAM address bits; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- ALMOST_FULL_THRESH, 2: almost_full_o asserts when free slots <= this value; legal range 1..2**ADDR_WIDTH-1.

Ports:
- clk  input  1  write-domain clock.
- reset  input  1  asynchronous, active-low reset.
- wr_en_i  input  1  write request for this cycle.
- rd_gray_sync_i  input  ADDR_WIDTH+1  read pointer in Gray code, already synchronized into clk.
- wr_addr_o  output  ADDR_WIDTH  RAM write address (low bits of the binary pointer).
- wr_gray_o  output  ADDR_WIDTH+1  registered Gray write pointer, routed to the read-domain synchronizer.
- wr_accept_o  output  1  wr_en_i && !full_o; combinational; the RAM write strobe.
- full_o  output  1  FIFO full, registered.
- almost_full_o  output  1  free slots <= ALMOST_FULL_THRESH, registered.
- overflow_o  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (reset low, asynchronous assert):
  - binary pointer, wr_gray_o, full_o, almost_full_o and overflow_o all go to 0.
  - Release is sampled on clk; no writes are accepted while reset is low.
- Pointer update:
  - wbin_next = wbin + wr_accept_o, modulo 2**(ADDR_WIDTH+1).
  - gray_next = wbin_next ^ (wbin_next >> 1).
  - Both register on posedge clk.
  - wr_addr_o = wbin[ADDR_WIDTH-1:0], so it shows the slot for the current write.
- wr_gray_o comes straight from a flop, with no logic after it.
  - Between consecutive cycles it changes in at most one bit.
  - It changes only in a cycle after an accepted write.
- Full:
  - full_o register <= (gray_next == {~rd_gray_sync_i[A:A-1], rd_gray_sync_i[A-2:0]}), where A = ADDR_WIDTH.
  - Because it is computed from the next pointer, full_o asserts in the same cycle the pointer reaches depth, with no extra latency.
- Almost-full:
  - rbin = Gray-to-binary of rd_gray_sync_i (prefix XOR from the MSB).
  - used_next = wbin_next - rbin, modulo 2**(A+1); range 0..depth.
  - almost_full_o register <= (depth - used_next) <= ALMOST_FULL_THRESH.
  - almost_full_o is 1 whenever full_o is 1.
- Writes while full:
  - wr_en_i with full_o=1 is not accepted: pointer holds and wr_accept_o=0.
  - overflow_o sets on the next edge and stays set until reset.
- Read pointer advancing, with no write that cycle:
  - full_o and almost_full_o deassert on the next edge, based on the new rd_gray_sync_i.
  - This is conservative: status lags real reads by the synchronizer delay, so full is never under-reported.
- Write and read-pointer change in the same cycle:
  - Evaluate with wbin_next and the current rd_gray_sync_i; no special case.
- Wrap-around:
  - The extra MSB distinguishes full from empty.
  - Pointer wraps from 2**(A+1)-1 to 0 (Gray 10..0 to 00..0), a single-bit change.
- Reset mid-operation:
  - Pointers and flags clear immediately; a write in flight is discarded.
  - The read domain must be reset in the same reset episode.

Test Plan:
1. Reset: ADDR_WIDTH=2, THRESH=1; assert reset low asynchronously mid-cycle.
   -> All outputs read 0 before the next clk edge; wr_addr_o=0, wr_gray_o=000.
2. Fill: ADDR_WIDTH=2, THRESH=1, rd_gray_sync_i=000; wr_en_i=1 for 5 cycles.
   -> wr_gray_o sequence 001,011,010,110.
   -> almost_full_o=1 after the 3rd write; full_o=1 after the 4th.
   -> 5th cycle: wr_accept_o=0 and pointer holds; overflow_o=1 on the next edge and stays set.
3. Drain from full: from state 2, set rd_gray_sync_i=001 (one read).
   -> Next edge full_o=0, almost_full_o=1, overflow_o still 1.
   -> One write, then full_o=1 with wr_gray_o=111.
4. Wrap: cycle 20 writes with rd_gray_sync_i tracking wr_gray_o two cycles late.
   -> Pointer wraps 7->0 (Gray 100->000); full_o never asserts.
   -> Every wr_gray_o transition is Hamming distance 1.
5. Simultaneous: at used=3 (depth 4), write and read-pointer advance in the same cycle.
   -> used stays 3; full_o=0, almost_full_o=1.
6. Random: random wr_en_i against a model read side with a 2-flop delay.
   -> Scoreboard never sees more than 4 entries.
   -> overflow_o asserts exactly on the first refused write.
